// File: rtl/ibuffer_mw_if.sv
// ibuffer_mw_if: fetch-to-decode bus of the multi-lane instruction buffer.
interface ibuffer_mw_if #(
    parameter int FETCH_W = 4,
    parameter int DEQ_W   = 2,
    parameter int DEPTH   = 16,
    parameter int PC_W    = 64
);
    logic                         redirect_valid;
    logic                         enq_valid;
    logic [FETCH_W-1:0]           enq_lane_valid;
    logic [PC_W-1:0]              enq_pc;
    logic [FETCH_W*32-1:0]        enq_instr;
    logic [FETCH_W-1:0]           enq_ptaken;
    logic [FETCH_W*32-1:0]        enq_ptarget;
    logic                         enq_ready;
    logic [DEQ_W-1:0]             deq_valid;
    logic [DEQ_W*32-1:0]          deq_instr;
    logic [DEQ_W*PC_W-1:0]        deq_pc;
    logic [DEQ_W-1:0]             deq_ptaken;
    logic [DEQ_W*32-1:0]          deq_ptarget;
    logic [DEQ_W-1:0]             deq_ready;
    logic                         backend_stall;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         fetch_req;

    modport master (
        output redirect_valid, enq_valid, enq_lane_valid, enq_pc, enq_instr, enq_ptaken,
               enq_ptarget, deq_ready, backend_stall,
        input  enq_ready, deq_valid, deq_instr, deq_pc, deq_ptaken, deq_ptarget, count, fetch_req
    );
    modport slave (
        input  redirect_valid, enq_valid, enq_lane_valid, enq_pc, enq_instr, enq_ptaken,
               enq_ptarget, deq_ready, backend_stall,
        output enq_ready, deq_valid, deq_instr, deq_pc, deq_ptaken, deq_ptarget, count, fetch_req
    );
endinterface

// File: rtl/ibuffer_mw.sv
// ibuffer_mw: compacts sparse fetch lanes into a circular queue and presents the oldest DEQ_W entries.
module ibuffer_mw #(
    parameter int FETCH_W = 4,
    parameter int DEQ_W   = 2,
    parameter int DEPTH   = 16,
    parameter int LOW_WM  = 8,
    parameter int PC_W    = 64
) (
    input logic          clock,
    input logic          reset_n,
    ibuffer_mw_if.slave  ib
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(FETCH_W+1);

    logic [31:0]      r_instr   [DEPTH];
    logic [PC_W-1:0]  r_pc      [DEPTH];
    logic [31:0]      r_ptarget [DEPTH];
    logic [DEPTH-1:0] r_ptaken;
    logic [AW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    logic             r_fetch_req;

    logic [NW-1:0]    w_ofs [FETCH_W];
    logic [NW-1:0]    w_n;
    logic [CW-1:0]    w_m, w_count_next;
    logic [DEQ_W-1:0] w_deq_valid;
    logic             w_go, w_enq_ready, w_fire;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_ofs[i] = w_n;
            w_n = w_n + NW'(ib.enq_lane_valid[i]);
        end
    end

    assign w_enq_ready = r_count <= CW'(DEPTH - FETCH_W);
    assign w_fire      = ib.enq_valid & w_enq_ready & ~ib.redirect_valid;

    // Dequeue only the leading run of accepted slots.
    always_comb begin
        w_m = '0;
        w_deq_valid = '0;
        w_go = ~ib.backend_stall;
        for (int j = 0; j < DEQ_W; j++) begin
            w_deq_valid[j] = (r_count > CW'(j)) & ~ib.redirect_valid;
            w_go = w_go & w_deq_valid[j] & ib.deq_ready[j];
            w_m = w_m + CW'(w_go);
        end
    end

    assign w_count_next = ib.redirect_valid ? '0 : r_count + (w_fire ? CW'(w_n) : '0) - w_m;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_fetch_req <= 1'b1;
        end else begin
            r_head      <= ib.redirect_valid ? '0 : r_head + AW'(w_m);
            r_tail      <= ib.redirect_valid ? '0 : w_fire ? r_tail + AW'(w_n) : r_tail;
            r_count     <= w_count_next;
            r_fetch_req <= w_count_next <= CW'(LOW_WM);
        end
    end

    always_ff @(posedge clock) begin
        if (w_fire)
            for (int i = 0; i < FETCH_W; i++)
                if (ib.enq_lane_valid[i]) begin
                    r_instr[r_tail + AW'(w_ofs[i])]   <= ib.enq_instr[32*i +: 32];
                    r_pc[r_tail + AW'(w_ofs[i])]      <= ib.enq_pc + PC_W'(4*i);
                    r_ptaken[r_tail + AW'(w_ofs[i])]  <= ib.enq_ptaken[i];
                    r_ptarget[r_tail + AW'(w_ofs[i])] <= ib.enq_ptarget[32*i +: 32];
                end
    end

    always_comb begin
        ib.deq_instr   = '0;
        ib.deq_pc      = '0;
        ib.deq_ptaken  = '0;
        ib.deq_ptarget = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            ib.deq_instr[32*j +: 32]     = r_instr[r_head + AW'(j)];
            ib.deq_pc[PC_W*j +: PC_W]    = r_pc[r_head + AW'(j)];
            ib.deq_ptaken[j]             = r_ptaken[r_head + AW'(j)];
            ib.deq_ptarget[32*j +: 32]   = r_ptarget[r_head + AW'(j)];
        end
    end

    assign ib.deq_valid = w_deq_valid;
    assign ib.enq_ready = w_enq_ready;
    assign ib.count     = r_count;
    assign ib.fetch_req = r_fetch_req;
endmodule

// File: tb/tb_ibuffer_mw.sv
// tb_ibuffer_mw: directed stimulus with a scoreboard queue checked by an independent dequeue monitor.
module tb_ibuffer_mw;
    localparam int FW = 4, DW = 2, DEPTH = 16, PW = 64;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ibuffer_mw_if #(.FETCH_W(FW), .DEQ_W(DW), .DEPTH(DEPTH), .PC_W(PW)) ib();
    ibuffer_mw #(.FETCH_W(FW), .DEQ_W(DW), .DEPTH(DEPTH), .LOW_WM(8), .PC_W(PW))
        dut (.clock(clock), .reset_n(reset_n), .ib(ib));

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t sb[$];
    int errors = 0, checks = 0;
    int mcount = 0, mnext = 0;

    function automatic ent_t mk(input logic [63:0] pc);
        ent_t e;
        e.pc = pc;
        e.instr = pc[31:0] ^ 32'h5A5A_0000;
        e.pt = pc[2];
        e.tgt = pc[31:0] + 32'h40;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, record what a correct buffer must emit, and advance the count model.
    task automatic drive(input logic ev, input logic [3:0] mask, input logic [63:0] pc,
                         input logic [1:0] dr, input logic bs, input logic rd);
        ent_t e;
        int m;
        logic go;
        ib.enq_valid = ev;
        ib.enq_lane_valid = mask;
        ib.enq_pc = pc;
        for (int i = 0; i < FW; i++) begin
            e = mk(pc + 64'(4*i));
            ib.enq_instr[32*i +: 32] = e.instr;
            ib.enq_ptaken[i] = e.pt;
            ib.enq_ptarget[32*i +: 32] = e.tgt;
        end
        ib.deq_ready = dr;
        ib.backend_stall = bs;
        ib.redirect_valid = rd;
        if (rd) sb.delete();
        else if (ev && mcount <= DEPTH - FW)
            for (int i = 0; i < FW; i++)
                if (mask[i]) sb.push_back(mk(pc + 64'(4*i)));
        m = 0;
        go = !bs && !rd;
        for (int j = 0; j < DW; j++) begin
            go = go && (mcount > j) && dr[j];
            if (go) m++;
        end
        mnext = rd ? 0 : mcount + ((ev && mcount <= DEPTH - FW) ? $countones(mask) : 0) - m;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        mcount = mnext;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic run(input logic ev, input logic [3:0] mask, input logic [63:0] pc,
                       input logic [1:0] dr, input logic bs);
        drive(ev, mask, pc, dr, bs, 1'b0);
        step();
    endtask

    task automatic chk_state(input string name, input int cnt, input logic rdy, input logic [1:0] dv, input logic fr);
        chk({name, "_count"}, 64'(ib.count), 64'(cnt));
        chk({name, "_enq_ready"}, 64'(ib.enq_ready), 64'(rdy));
        chk({name, "_deq_valid"}, 64'(ib.deq_valid), 64'(dv));
        chk({name, "_fetch_req"}, 64'(ib.fetch_req), 64'(fr));
    endtask

    // Monitor: every slot the DUT hands to decode must be the oldest outstanding expected entry.
    always @(negedge clock) begin
        logic go;
        ent_t e, a;
        if (reset_n) begin
            go = !ib.backend_stall;
            for (int j = 0; j < DW; j++) begin
                go = go & ib.deq_valid[j] & ib.deq_ready[j];
                if (go) begin
                    a.pc = ib.deq_pc[PW*j +: PW];
                    a.instr = ib.deq_instr[32*j +: 32];
                    a.pt = ib.deq_ptaken[j];
                    a.tgt = ib.deq_ptarget[32*j +: 32];
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL deq_unexpected slot%0d: got pc %0h expected no entry", j, a.pc);
                    end else begin
                        e = sb.pop_front();
                        if (a !== e) begin
                            errors++;
                            $display("FAIL deq_data slot%0d: got pc %0h instr %0h pt %0b tgt %0h expected pc %0h instr %0h pt %0b tgt %0h",
                                     j, a.pc, a.instr, a.pt, a.tgt, e.pc, e.instr, e.pt, e.tgt);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) step();
        chk_state("reset", 0, 1'b1, 2'b00, 1'b1);
        reset_n = 1'b1;
        repeat (5) step();
        chk_state("idle5", 0, 1'b1, 2'b00, 1'b1);

        // Sparse compaction
        run(1'b1, 4'b1011, 64'h8000_0000, 2'b00, 1'b0);
        idle();
        chk_state("sparse", 3, 1'b1, 2'b11, 1'b1);
        chk("sparse_pc0", ib.deq_pc[63:0], 64'h8000_0000);
        chk("sparse_pc1", ib.deq_pc[127:64], 64'h8000_0004);
        run(1'b0, 4'h0, 64'h0, 2'b11, 1'b0);
        idle();
        chk("sparse_count_after", 64'(ib.count), 64'd1);
        chk("sparse_pc0_after", ib.deq_pc[63:0], 64'h8000_000C);
        run(1'b0, 4'h0, 64'h0, 2'b01, 1'b0);
        idle();
        chk("sparse_drained", 64'(ib.count), 64'd0);

        // Fill to capacity; an extra packet is refused
        for (int k = 0; k < 3; k++) run(1'b1, 4'hF, 64'h1000 + 64'(16*k), 2'b00, 1'b0);
        idle();
        chk_state("full12", 12, 1'b1, 2'b11, 1'b0);
        run(1'b1, 4'hF, 64'h1030, 2'b00, 1'b0);
        idle();
        chk_state("full16", 16, 1'b0, 2'b11, 1'b0);
        run(1'b1, 4'hF, 64'h9000, 2'b00, 1'b0);
        idle();
        chk("full_drop_count", 64'(ib.count), 64'd16);
        repeat (8) run(1'b0, 4'h0, 64'h0, 2'b11, 1'b0);
        idle();
        chk_state("full_drained", 0, 1'b1, 2'b00, 1'b1);

        // Pointer wrap with simultaneous enqueue and dequeue
        for (int k = 0; k < 3; k++) run(1'b1, 4'hF, 64'h2000 + 64'(16*k), 2'b00, 1'b0);
        run(1'b1, 4'b0011, 64'h2030, 2'b00, 1'b0);
        idle();
        chk("wrap_pre", 64'(ib.count), 64'd14);
        repeat (6) run(1'b0, 4'h0, 64'h0, 2'b11, 1'b0);
        idle();
        chk("wrap_deq12", 64'(ib.count), 64'd2);
        for (int k = 0; k < 6; k++) begin
            run(1'b1, 4'hF, 64'h3000 + 64'(16*k), 2'b11, 1'b0);
            idle();
            chk("wrap_count", 64'(ib.count), 64'(4 + 2*k));
            chk("wrap_enq_ready", 64'(ib.enq_ready), 64'((4 + 2*k) <= 12));
        end
        repeat (7) run(1'b0, 4'h0, 64'h0, 2'b11, 1'b0);
        idle();
        chk("wrap_drained", 64'(ib.count), 64'd0);

        // Redirect discards same-cycle enqueue and dequeue
        run(1'b1, 4'hF, 64'h4000, 2'b00, 1'b0);
        run(1'b1, 4'b0001, 64'h4010, 2'b00, 1'b0);
        idle();
        chk("redir_pre", 64'(ib.count), 64'd5);
        drive(1'b1, 4'hF, 64'h5000, 2'b11, 1'b0, 1'b1);
        chk("redir_deq_valid", 64'(ib.deq_valid), 64'd0);
        step();
        idle();
        chk_state("redir_post", 0, 1'b1, 2'b00, 1'b1);
        run(1'b1, 4'hF, 64'h6000, 2'b00, 1'b0);
        repeat (2) run(1'b0, 4'h0, 64'h0, 2'b11, 1'b0);
        idle();
        chk("redir_drained", 64'(ib.count), 64'd0);

        // Handshake gating
        run(1'b1, 4'hF, 64'h7000, 2'b00, 1'b0);
        idle();
        chk("gate_pre", 64'(ib.count), 64'd4);
        run(1'b0, 4'h0, 64'h0, 2'b10, 1'b0);
        idle();
        chk("gate_ready10", 64'(ib.count), 64'd4);
        run(1'b0, 4'h0, 64'h0, 2'b11, 1'b1);
        idle();
        chk("gate_stall", 64'(ib.count), 64'd4);
        run(1'b0, 4'h0, 64'h0, 2'b01, 1'b0);
        idle();
        chk("gate_ready01", 64'(ib.count), 64'd3);
        chk("gate_pc0", ib.deq_pc[63:0], 64'h7004);
        repeat (2) run(1'b0, 4'h0, 64'h0, 2'b11, 1'b0);
        idle();
        chk("gate_drained", 64'(ib.count), 64'd0);

        // Asynchronous reset mid-operation
        run(1'b1, 4'hF, 64'hA000, 2'b00, 1'b0);
        idle();
        reset_n = 1'b0;
        #1;
        sb.delete();
        mcount = 0;
        mnext = 0;
        chk_state("async_reset", 0, 1'b1, 2'b00, 1'b1);
        step();
        reset_n = 1'b1;
        step();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
